// File: rtl/echo_delay_ctrl.sv
// echo_delay_ctrl
// ---------------
// Delay-line controller for the echo effect. Accepts one signed sample per
// handshake and owns the write and read pointers of the ring-buffer sample RAM
// placed directly downstream. For each sample it reads the delayed sample,
// mixes a scaled echo into the dry signal, writes back to the RAM and emits
// the mixed sample.
//
// Each sample takes four clocks: IDLE (accept) -> READ -> MIX -> WRITE.
//
// Optional feature macro: ECHO_FEEDBACK_EN
//   defined   : the RAM stores the mixed sum, so the echo regenerates and
//               decays geometrically on every pass.
//   undefined : the RAM stores the dry sample, so there is a single echo.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     one-cycle strobe qualifying in_sample (dropped unless in_ready)
//   in_ready     high only while idle
//   in_sample    dry sample, signed
//   delay_len    echo delay in samples, latched at acceptance
//   decay        echo gain, unsigned Q0.8, used in MIX
//   bypass       zeroes the wet term on out_sample only, used in MIX
//   out_valid    one-cycle strobe qualifying out_sample
//   out_sample   mixed sample, held until the next out_valid
//   mem_w_en     RAM write enable (high only in WRITE)
//   mem_w_addr   RAM write address
//   mem_r_addr   RAM read address
//   mem_d_in     RAM write data
//   mem_d_out    RAM read data, combinational from mem_r_addr
module echo_delay_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 29281
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sample,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [7:0]        decay,
  input  logic              bypass,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sample,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [DATA_W-1:0] mem_d_in,
  input  logic [DATA_W-1:0] mem_d_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MIX   = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0]        DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0]        DEPTH_M1 = ADDR_W'(DEPTH - 1);
  localparam logic signed [DATA_W-1:0] SMAX     = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMIN     = {1'b1, {(DATA_W-1){1'b0}}};

  // Echo gain: signed sample times {0,decay}, arithmetic shift right by 8.
  // The 25-bit product shifted by 8 always fits in DATA_W+1 bits.
  function automatic logic signed [DATA_W:0] scale_wet(
    input logic signed [DATA_W-1:0] s,
    input logic [7:0]               g
  );
    logic signed [DATA_W+8:0] prod;
    prod = s * $signed({1'b0, g});
    return prod[DATA_W+8:8];
  endfunction

  // Clamp a DATA_W+1 bit sum back into the DATA_W signed range.
  function automatic logic signed [DATA_W-1:0] sat_sum(
    input logic signed [DATA_W:0] v
  );
    if (v[DATA_W] != v[DATA_W-1]) begin
      return v[DATA_W] ? SMIN : SMAX;
    end
    return v[DATA_W-1:0];
  endfunction

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        fill_q, fill_d;
  logic [ADDR_W-1:0]        mem_r_addr_q, mem_r_addr_d;
  logic [ADDR_W-1:0]        mem_w_addr_q, mem_w_addr_d;
  logic                     mem_w_en_q, mem_w_en_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_sample_q, out_sample_d;
  logic signed [DATA_W-1:0] mem_d_in_q, mem_d_in_d;

  // Datapath holding registers; no reset needed, only written on the path
  // from acceptance onward.
  logic signed [DATA_W-1:0] x_q, x_d;
  logic signed [DATA_W-1:0] dly_q, dly_d;
  logic [ADDR_W-1:0]        d_q, d_d;

  logic [ADDR_W-1:0]        d_eff;
  logic signed [DATA_W:0]   wet;
  logic signed [DATA_W:0]   sum_ext;
  logic signed [DATA_W-1:0] sum_sat;

  // Effective delay: 0 means 1, anything past the buffer means DEPTH-1.
  always_comb begin
    if (delay_len == '0) begin
      d_eff = ADDR_W'(1);
    end else if (delay_len >= DEPTH_A) begin
      d_eff = DEPTH_M1;
    end else begin
      d_eff = delay_len;
    end
  end

  always_comb begin
    wet     = scale_wet(dly_q, decay);
    sum_ext = $signed({x_q[DATA_W-1], x_q}) + wet;
    sum_sat = sat_sum(sum_ext);
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    mem_r_addr_d = mem_r_addr_q;
    mem_w_addr_d = mem_w_addr_q;
    mem_w_en_d   = 1'b0;
    out_valid_d  = 1'b0;
    out_sample_d = out_sample_q;
    mem_d_in_d   = mem_d_in_q;
    x_d          = x_q;
    dly_d        = dly_q;
    d_d          = d_q;

    unique case (state_q)
      // Accept: latch the sample and delay; the read address is registered
      // here so the RAM output is settled throughout READ.
      IDLE: begin
        if (in_valid) begin
          x_d   = $signed(in_sample);
          d_d   = d_eff;
          // Modular subtraction; the intermediate may exceed 2^ADDR_W but the
          // final result is below DEPTH.
          mem_r_addr_d = (wr_ptr_q >= d_eff) ? (wr_ptr_q - d_eff)
                                             : (wr_ptr_q + DEPTH_A - d_eff);
          state_d = READ;
        end
      end
      // Read: locations not yet written since reset count as silence.
      READ: begin
        dly_d   = (fill_q >= d_q) ? $signed(mem_d_out) : '0;
        state_d = MIX;
      end
      // Mix: results are registered so they appear as WRITE-state outputs.
      MIX: begin
        out_sample_d = bypass ? x_q : sum_sat;
`ifdef ECHO_FEEDBACK_EN
        mem_d_in_d   = sum_sat;
`else
        mem_d_in_d   = x_q;
`endif
        mem_w_addr_d = wr_ptr_q;
        mem_w_en_d   = 1'b1;
        out_valid_d  = 1'b1;
        state_d      = WRITE;
      end
      // Write: the RAM captures mem_d_in this cycle; advance the ring.
      WRITE: begin
        wr_ptr_d = (wr_ptr_q == DEPTH_M1) ? '0 : (wr_ptr_q + ADDR_W'(1));
        fill_d   = (fill_q == DEPTH_A) ? fill_q : (fill_q + ADDR_W'(1));
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      mem_r_addr_q <= '0;
      mem_w_addr_q <= '0;
      mem_w_en_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      mem_d_in_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      mem_r_addr_q <= mem_r_addr_d;
      mem_w_addr_q <= mem_w_addr_d;
      mem_w_en_q   <= mem_w_en_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      mem_d_in_q   <= mem_d_in_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q   <= x_d;
    dly_q <= dly_d;
    d_q   <= d_d;
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign mem_w_en   = mem_w_en_q;
  assign mem_w_addr = mem_w_addr_q;
  assign mem_r_addr = mem_r_addr_q;
  assign mem_d_in   = mem_d_in_q;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Testbench for echo_delay_ctrl. Two instances share one stimulus stream: the
// full-size buffer and a 13-entry buffer that wraps quickly. Each has its own
// RAM model and its own reference history of written samples.
module tb_echo_delay_ctrl;

`ifdef ECHO_FEEDBACK_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  localparam int DEPTH_BIG   = 29281;
  localparam int DEPTH_SMALL = 13;
  localparam int HIST        = 2048;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_sample;
  logic [14:0] delay_len;
  logic [7:0]  decay;
  logic        bypass;

  logic        in_ready   [2];
  logic        out_valid  [2];
  logic signed [15:0] out_sample [2];
  logic        mem_w_en   [2];
  logic [14:0] mem_w_addr [2];
  logic [14:0] mem_r_addr [2];
  logic signed [15:0] mem_d_in  [2];
  logic signed [15:0] mem_d_out [2];

  logic signed [15:0] ram0 [0:32767];
  logic signed [15:0] ram1 [0:32767];

  int n_checks;
  int n_err;
  int cnt  [2];
  int hist [2][0:HIST-1];

  typedef struct {
    int x;
    int dl;
    int dec;
    bit byp;
    bit rst_first;
    int exp_out;
  } vec_t;

  vec_t tab [0:31];
  int   n_tab;

  echo_delay_ctrl #(.DATA_W(16), .ADDR_W(15), .DEPTH(DEPTH_BIG)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_sample(in_sample), .delay_len(delay_len), .decay(decay), .bypass(bypass),
    .out_valid(out_valid[0]), .out_sample(out_sample[0]), .mem_w_en(mem_w_en[0]),
    .mem_w_addr(mem_w_addr[0]), .mem_r_addr(mem_r_addr[0]), .mem_d_in(mem_d_in[0]),
    .mem_d_out(mem_d_out[0])
  );

  echo_delay_ctrl #(.DATA_W(16), .ADDR_W(15), .DEPTH(DEPTH_SMALL)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_sample(in_sample), .delay_len(delay_len), .decay(decay), .bypass(bypass),
    .out_valid(out_valid[1]), .out_sample(out_sample[1]), .mem_w_en(mem_w_en[1]),
    .mem_w_addr(mem_w_addr[1]), .mem_r_addr(mem_r_addr[1]), .mem_d_in(mem_d_in[1]),
    .mem_d_out(mem_d_out[1])
  );

  always #5 clk = ~clk;

  assign mem_d_out[0] = ram0[mem_r_addr[0]];
  assign mem_d_out[1] = ram1[mem_r_addr[1]];

  always @(posedge clk) begin
    if (mem_w_en[0]) ram0[mem_w_addr[0]] <= mem_d_in[0];
    if (mem_w_en[1]) ram1[mem_w_addr[1]] <= mem_d_in[1];
  end

  task automatic chk(input string name, input int inst, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", name, inst, act, exp_v, $time);
    end
  endtask

  // Reference: sample k with delay d echoes whatever was written for sample
  // k-d; before that sample exists the echo is silence.
  task automatic model(input int i, input int x, input int dl, input int dec, input bit byp,
                       output int o, output int wa, output int ra, output int wd);
    int depth, d, k, dly, p, wet, sum;
    depth = (i == 0) ? DEPTH_BIG : DEPTH_SMALL;
    if (dl == 0) d = 1;
    else if (dl >= depth) d = depth - 1;
    else d = dl;
    k   = cnt[i];
    dly = (k >= d) ? hist[i][k-d] : 0;
    p   = dly * dec;
    wet = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    sum = x + wet;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    o  = byp ? x : sum;
    wd = FB ? sum : x;
    wa = k % depth;
    ra = ((k - d) % depth + depth) % depth;
    if (k < HIST) hist[i][k] = wd;
    cnt[i] = k + 1;
  endtask

  task automatic chk_reset_vals();
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_sample", i, int'(out_sample[i]), 0);
      chk("rst_out_valid", i, int'(out_valid[i]), 0);
      chk("rst_mem_w_en", i, int'(mem_w_en[i]), 0);
      chk("rst_mem_w_addr", i, int'(mem_w_addr[i]), 0);
      chk("rst_mem_r_addr", i, int'(mem_r_addr[i]), 0);
      chk("rst_mem_d_in", i, int'(mem_d_in[i]), 0);
      chk("rst_in_ready", i, int'(in_ready[i]), 1);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    repeat (n) @(negedge clk);
    rst = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("idle_out_valid", i, int'(out_valid[i]), 0);
        chk("idle_mem_w_en", i, int'(mem_w_en[i]), 0);
      end
    end
  endtask

  // One full transaction. With noise set, in_valid is held high (with junk
  // data) through READ, MIX and WRITE, which must all be ignored.
  task automatic do_sample(input int x, input int dl, input int dec, input bit byp,
                           input bit noise, input bit use_exp, input int exp_out);
    int e_o [2];
    int e_wa[2];
    int e_ra[2];
    int e_wd[2];
    for (int i = 0; i < 2; i++) model(i, x, dl, dec, byp, e_o[i], e_wa[i], e_ra[i], e_wd[i]);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("pre_in_ready", i, int'(in_ready[i]), 1);
    in_valid  = 1'b1;
    in_sample = 16'(x);
    delay_len = 15'(dl);
    decay     = 8'(dec);
    bypass    = byp;
    @(posedge clk);
    #1;
    in_valid = noise;
    if (noise) begin
      in_sample = 16'($urandom);
      delay_len = 15'($urandom);
    end
    for (int i = 0; i < 2; i++) begin
      chk("read_mem_r_addr", i, int'(mem_r_addr[i]), e_ra[i]);
      chk("read_in_ready", i, int'(in_ready[i]), 0);
      chk("read_out_valid", i, int'(out_valid[i]), 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mix_out_valid", i, int'(out_valid[i]), 0);
      chk("mix_mem_w_en", i, int'(mem_w_en[i]), 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("wr_out_valid", i, int'(out_valid[i]), 1);
      chk("wr_mem_w_en", i, int'(mem_w_en[i]), 1);
      chk("wr_out_sample", i, int'(out_sample[i]), e_o[i]);
      chk("wr_mem_w_addr", i, int'(mem_w_addr[i]), e_wa[i]);
      chk("wr_mem_d_in", i, int'(mem_d_in[i]), e_wd[i]);
    end
    if (use_exp) chk("vector_out", 0, int'(out_sample[0]), exp_out);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("idle_in_ready", i, int'(in_ready[i]), 1);
      chk("idle_out_valid", i, int'(out_valid[i]), 0);
      chk("idle_mem_w_en", i, int'(mem_w_en[i]), 0);
      chk("hold_out_sample", i, int'(out_sample[i]), e_o[i]);
    end
  endtask

  // Accept a sample, then reset asynchronously while it is in MIX.
  task automatic abort_in_mix(input int x);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sample = 16'(x);
    delay_len = 15'd5;
    decay     = 8'd128;
    bypass    = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals();
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("abort_out_valid", i, int'(out_valid[i]), 0);
        chk("abort_mem_w_en", i, int'(mem_w_en[i]), 0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    cnt[0] = 0;
    cnt[1] = 0;
    idle_check(4);
  endtask

  task automatic add_vec(input int x, input int dl, input int dec, input bit byp,
                         input bit rf, input int e);
    tab[n_tab].x         = x;
    tab[n_tab].dl        = dl;
    tab[n_tab].dec       = dec;
    tab[n_tab].byp       = byp;
    tab[n_tab].rst_first = rf;
    tab[n_tab].exp_out   = e;
    n_tab++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, dl, dec;
    bit byp, noise;
    clk = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sample = '0;
    delay_len = '0;
    decay = '0;
    bypass = 1'b0;
    n_checks = 0;
    n_err = 0;
    n_tab = 0;
    cnt[0] = 0;
    cnt[1] = 0;

    // Impulse: delay 4, decay one half.
    add_vec(16384, 4, 128, 1'b0, 1'b1, 16384);
    for (int j = 1; j <= 8; j++) begin
      add_vec(0, 4, 128, 1'b0, 1'b0,
              (j == 4) ? 8192 : ((j == 8) ? (FB ? 4096 : 0) : 0));
    end
    // Saturation in both directions.
    add_vec(30000, 1, 255, 1'b0, 1'b1, 30000);
    add_vec(30000, 1, 255, 1'b0, 1'b0, 32767);
    add_vec(-30000, 1, 255, 1'b0, 1'b1, -30000);
    add_vec(-30000, 1, 255, 1'b0, 1'b0, -32768);
    // Bypass passes x straight through while the RAM write continues.
    add_vec(30000, 1, 255, 1'b1, 1'b0, 30000);
    add_vec(0, 1, 255, 1'b0, 1'b0, FB ? -2630 : 29882);
    // delay_len 0 behaves as 1.
    add_vec(100, 0, 255, 1'b0, 1'b1, 100);
    add_vec(0, 0, 255, 1'b0, 1'b0, 99);

    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;

    for (int t = 0; t < n_tab; t++) begin
      if (tab[t].rst_first) do_reset(2);
      do_sample(tab[t].x, tab[t].dl, tab[t].dec, tab[t].byp, 1'b0, 1'b1, tab[t].exp_out);
    end

    // in_valid pulses while busy must be dropped.
    do_reset(2);
    do_sample(1000, 3, 100, 1'b0, 1'b1, 1'b1, 1000);
    do_sample(-2000, 2, 200, 1'b0, 1'b1, 1'b0, 0);
    do_sample(500, 1, 64, 1'b0, 1'b1, 1'b0, 0);
    idle_check(6);

    // Wrap-around: the small buffer at its maximum delay, plus the clamp of
    // an oversize delay on both buffers.
    do_reset(2);
    for (int j = 0; j < 30; j++) begin
      do_sample($urandom_range(0, 65535) - 32768, 12, 200, 1'b0, 1'b0, 1'b0, 0);
    end
    do_sample(777, 32767, 255, 1'b0, 1'b0, 1'b0, 0);
    do_sample(-777, 29280, 255, 1'b0, 1'b0, 1'b0, 0);

    // Randomized traffic against the reference history.
    for (int j = 0; j < 400; j++) begin
      x = $urandom_range(0, 65535) - 32768;
      if ($urandom_range(0, 3) == 0) begin
        x = ($urandom_range(0, 1) == 1) ? 32767 - $urandom_range(0, 500)
                                         : -32768 + $urandom_range(0, 500);
      end
      case ($urandom_range(0, 9))
        0: dl = 0;
        1: dl = 29280;
        2: dl = $urandom_range(29281, 32767);
        3: dl = $urandom_range(12, 14);
        default: dl = $urandom_range(1, 20);
      endcase
      dec   = $urandom_range(0, 255);
      byp   = ($urandom_range(0, 7) == 0);
      noise = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 99) == 0) do_reset(1);
      do_sample(x, dl, dec, byp, noise, 1'b0, 0);
    end

    // Reset in the middle of a sample, then restart from an empty buffer.
    do_sample(4321, 2, 255, 1'b0, 1'b0, 1'b0, 0);
    abort_in_mix(-1234);
    do_sample(1234, 5, 200, 1'b0, 1'b0, 1'b1, 1234);
    chk("post_abort_second_waddr", 0, int'(mem_w_addr[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
